// File: rtl/vproc_result_rob_if.sv
// Result handshake bundle for vproc_result_rob: per-channel result inputs
// from the producers plus the single in-order XIF result output.
interface vproc_result_rob_if #(
    parameter int unsigned XIF_ID_W = 3,
    parameter int unsigned NUM_CH   = 3
);
    logic [NUM_CH-1:0]          ch_valid_i;
    logic [NUM_CH-1:0]          ch_ready_o;
    logic [NUM_CH*XIF_ID_W-1:0] ch_id_i;
    logic [NUM_CH*32-1:0]       ch_data_i;
    logic [NUM_CH*5-1:0]        ch_rd_i;
    logic [NUM_CH-1:0]          ch_we_i;
    logic [NUM_CH-1:0]          ch_exc_i;
    logic [NUM_CH*6-1:0]        ch_exccode_i;

    logic                       res_valid_o;
    logic                       res_ready_i;
    logic [XIF_ID_W-1:0]        res_id_o;
    logic [31:0]                res_data_o;
    logic [4:0]                 res_rd_o;
    logic                       res_we_o;
    logic                       res_exc_o;
    logic [5:0]                 res_exccode_o;

    // Producer/consumer side (drives channels, accepts results)
    modport master (
        output ch_valid_i, ch_id_i, ch_data_i, ch_rd_i, ch_we_i, ch_exc_i, ch_exccode_i,
        input  ch_ready_o,
        input  res_valid_o, res_id_o, res_data_o, res_rd_o, res_we_o, res_exc_o, res_exccode_o,
        output res_ready_i
    );

    // Reorder buffer side
    modport slave (
        input  ch_valid_i, ch_id_i, ch_data_i, ch_rd_i, ch_we_i, ch_exc_i, ch_exccode_i,
        output ch_ready_o,
        output res_valid_o, res_id_o, res_data_o, res_rd_o, res_we_o, res_exc_o, res_exccode_o,
        input  res_ready_i
    );
endinterface

// File: rtl/vproc_result_rob.sv
// Result reorder buffer: collects out-of-order results from NUM_CH producer
// channels into ID-indexed slots and retires them strictly in ID order.
// Killed IDs retire silently. Define VPROC_RESULT_BYPASS_EN to forward a
// result arriving for the retire pointer in the same cycle.
module vproc_result_rob #(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned NUM_CH         = 3,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                clk_i,
    input  logic                async_rst_ni,
    vproc_result_rob_if.slave   bus,
    input  logic                kill_valid_i,
    input  logic [XIF_ID_W-1:0] kill_id_i,
    output logic [XIF_ID_W-1:0] next_id_o,
    output logic [XIF_ID_W:0]   occupancy_o
);

    localparam int unsigned ID_CNT = 1 << XIF_ID_W;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [5:0]  exccode;
    } payload_t;

    logic [ID_CNT-1:0]   full_q, full_d;
    logic [ID_CNT-1:0]   killed_q, killed_d;
    payload_t            slot_q [ID_CNT];
    payload_t            slot_d [ID_CNT];
    logic [XIF_ID_W-1:0] next_id_q, next_id_d;
    logic [XIF_ID_W:0]   occ_q, occ_d;

    logic [XIF_ID_W-1:0] ch_id [NUM_CH];
    payload_t            ch_pl [NUM_CH];
    logic [NUM_CH-1:0]   ch_acc;

    logic                byp_hit;
    payload_t            byp_pl;
    logic                res_valid;
    payload_t            res_pl;
    logic                retire;

    // Unpack the flat per-channel buses
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_id[i]          = bus.ch_id_i[i*XIF_ID_W +: XIF_ID_W];
            ch_pl[i].data     = bus.ch_data_i[i*32 +: 32];
            ch_pl[i].rd       = bus.ch_rd_i[i*5 +: 5];
            ch_pl[i].we       = bus.ch_we_i[i];
            ch_pl[i].exc      = bus.ch_exc_i[i];
            ch_pl[i].exccode  = bus.ch_exccode_i[i*6 +: 6];
        end
    end

    // Accept a channel when its slot is free and no lower channel claims the same ID
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_acc[i] = async_rst_ni & bus.ch_valid_i[i] & ~full_q[ch_id[i]];
            for (int unsigned j = 0; j < i; j++) begin
                if (bus.ch_valid_i[j] && (ch_id[j] == ch_id[i])) begin
                    ch_acc[i] = 1'b0;
                end
            end
        end
    end

    assign bus.ch_ready_o = ch_acc;

`ifdef VPROC_RESULT_BYPASS_EN
    // Forward a result headed for the retire pointer in the same cycle it arrives
    always_comb begin
        byp_hit = 1'b0;
        byp_pl  = '0;
        if (!full_q[next_id_q] && !(kill_valid_i && (kill_id_i == next_id_q))) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_acc[i] && (ch_id[i] == next_id_q)) begin
                    byp_hit = 1'b1;
                    byp_pl  = ch_pl[i];
                end
            end
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_pl  = '0;
`endif

    // Select the result presented at the retire pointer
    always_comb begin
        res_valid = 1'b0;
        res_pl    = '0;
        if (byp_hit) begin
            res_valid = 1'b1;
            res_pl    = byp_pl;
        end else if (full_q[next_id_q] && !killed_q[next_id_q]) begin
            res_valid = 1'b1;
            res_pl    = slot_q[next_id_q];
        end
    end

    assign retire = (res_valid && bus.res_ready_i) || (full_q[next_id_q] && killed_q[next_id_q]);

    assign bus.res_valid_o   = res_valid;
    assign bus.res_id_o      = res_valid      ? next_id_q :
                               DONT_CARE_ZERO ? '0        : 'x;
    assign bus.res_data_o    = res_pl.data;
    assign bus.res_rd_o      = res_pl.rd;
    assign bus.res_we_o      = res_pl.we;
    assign bus.res_exc_o     = res_pl.exc;
    assign bus.res_exccode_o = res_pl.exccode;

    assign next_id_o   = next_id_q;
    assign occupancy_o = occ_q;

    // Slot update: retire first, then channel fills, then kills override
    always_comb begin
        full_d    = full_q;
        killed_d  = killed_q;
        slot_d    = slot_q;
        next_id_d = next_id_q;
        if (retire) begin
            full_d[next_id_q]   = 1'b0;
            killed_d[next_id_q] = 1'b0;
            next_id_d           = next_id_q + XIF_ID_W'(1);
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_acc[i]) begin
                full_d[ch_id[i]] = 1'b1;
                slot_d[ch_id[i]] = ch_pl[i];
            end
        end
        // A bypassed result taken this cycle leaves its (still written) slot empty
        if (byp_hit && bus.res_ready_i) begin
            full_d[next_id_q] = 1'b0;
        end
        if (kill_valid_i) begin
            full_d[kill_id_i]   = 1'b1;
            killed_d[kill_id_i] = 1'b1;
        end
        occ_d = '0;
        for (int unsigned k = 0; k < ID_CNT; k++) begin
            occ_d = occ_d + (XIF_ID_W+1)'(full_d[k]);
        end
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            full_q    <= '0;
            killed_q  <= '0;
            next_id_q <= '0;
            occ_q     <= '0;
        end else begin
            full_q    <= full_d;
            killed_q  <= killed_d;
            next_id_q <= next_id_d;
            occ_q     <= occ_d;
        end
    end

    // Payload storage, qualified by the full flags so it needs no reset
    always_ff @(posedge clk_i) begin
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_vproc_result_rob.sv
// Scoreboard bench for vproc_result_rob (XIF_ID_W=3, NUM_CH=3).
module tb_vproc_result_rob;
    localparam int unsigned W   = 3;
    localparam int unsigned NCH = 3;

    typedef struct packed {
        logic [W-1:0] id;
        logic [31:0]  data;
        logic [4:0]   rd;
        logic         we;
        logic         exc;
        logic [5:0]   ec;
    } res_t;

    logic         clk_i = 1'b0;
    logic         async_rst_ni = 1'b0;
    logic         kill_valid_i;
    logic [W-1:0] kill_id_i;
    logic [W-1:0] next_id_o;
    logic [W:0]   occupancy_o;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q [$];

    vproc_result_rob_if #(.XIF_ID_W(W), .NUM_CH(NCH)) bus ();

    vproc_result_rob #(.XIF_ID_W(W), .NUM_CH(NCH), .DONT_CARE_ZERO(1'b0)) dut (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .bus          (bus.slave),
        .kill_valid_i (kill_valid_i),
        .kill_id_i    (kill_id_i),
        .next_id_o    (next_id_o),
        .occupancy_o  (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.ch_valid_i = '0;
        kill_valid_i   = 1'b0;
    endtask

    task automatic drv(input int unsigned ch, input res_t p);
        bus.ch_valid_i[ch]          = 1'b1;
        bus.ch_id_i[ch*W +: W]      = p.id;
        bus.ch_data_i[ch*32 +: 32]  = p.data;
        bus.ch_rd_i[ch*5 +: 5]      = p.rd;
        bus.ch_we_i[ch]             = p.we;
        bus.ch_exc_i[ch]            = p.exc;
        bus.ch_exccode_i[ch*6 +: 6] = p.ec;
    endtask

    // Hand-chosen payload pattern for the fill tests
    function automatic res_t pl(input logic [W-1:0] id);
        res_t r;
        r.id   = id;
        r.data = 32'hD000_0000 | {29'd0, id};
        r.rd   = 5'({2'b00, id} + 5'd1);
        r.we   = id[0];
        r.exc  = (id == 3'd5);
        r.ec   = 6'({3'b000, id} * 6'd3);
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] id, input logic [31:0] d, input logic [4:0] rd);
        res_t r;
        r.id   = id;
        r.data = d;
        r.rd   = rd;
        r.we   = 1'b1;
        r.exc  = 1'b0;
        r.ec   = 6'd0;
        return r;
    endfunction

    task automatic do_reset(input string tag);
        async_rst_ni = 1'b0;
        idle();
        bus.ch_valid_i[0] = 1'b1;
        #1;
        chk({tag, "_rst_ready"}, 64'(bus.ch_ready_o), 64'd0);
        chk({tag, "_rst_valid"}, 64'(bus.res_valid_o), 64'd0);
        chk({tag, "_rst_occ"}, 64'(occupancy_o), 64'd0);
        chk({tag, "_rst_next"}, 64'(next_id_o), 64'd0);
        idle();
        tick();
        async_rst_ni = 1'b1;
    endtask

    // Monitor: every completed result handshake is checked against the queue
    always @(negedge clk_i) begin
        res_t r;
        if (async_rst_ni && bus.res_valid_o && bus.res_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got id %0d data %h, required no result",
                         bus.res_id_o, bus.res_data_o);
            end else begin
                r = exp_q.pop_front();
                chk("sb_result",
                    64'({bus.res_id_o, bus.res_data_o, bus.res_rd_o, bus.res_we_o,
                         bus.res_exc_o, bus.res_exccode_o}),
                    64'(r));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int got;
        idle();
        kill_id_i        = '0;
        bus.res_ready_i  = 1'b0;
        bus.ch_id_i      = '0;
        bus.ch_data_i    = '0;
        bus.ch_rd_i      = '0;
        bus.ch_we_i      = '0;
        bus.ch_exc_i     = '0;
        bus.ch_exccode_i = '0;
        #2;
        do_reset("init");

        // In-order retirement of out-of-order writes
        bus.res_ready_i = 1'b1;
        exp_q.push_back(mk(3'd0, 32'h55, 5'd2));
        exp_q.push_back(mk(3'd1, 32'hAA, 5'd1));
        drv(1, mk(3'd1, 32'hAA, 5'd1));
        @(negedge clk_i) chk("t035_ready_a", 64'(bus.ch_ready_o), 64'b010);
        tick(); idle();
        drv(0, mk(3'd0, 32'h55, 5'd2));
        @(negedge clk_i) chk("t035_ready_b", 64'(bus.ch_ready_o), 64'b001);
        tick(); idle();
        tick(); tick();
        chk("t035_next", 64'(next_id_o), 64'd2);
        chk("t035_occ", 64'(occupancy_o), 64'd0);
        chk("t035_idle_valid", 64'(bus.res_valid_o), 64'd0);
        chk("t035_idle_data", 64'(bus.res_data_o), 64'd0);

        // Same-ID conflict: lower channel wins, loser stalls until the slot retires
        exp_q.push_back(mk(3'd2, 32'h22, 5'd7));
        exp_q.push_back(mk(3'd3, 32'h33, 5'd3));
        drv(0, mk(3'd3, 32'h33, 5'd3));
        drv(2, mk(3'd3, 32'h66, 5'd6));
        @(negedge clk_i) chk("t036_conflict", 64'(bus.ch_ready_o), 64'b001);
        tick();
        bus.ch_valid_i[0] = 1'b0;
        @(negedge clk_i) chk("t036_stall", 64'(bus.ch_ready_o), 64'b000);
        tick();
        drv(1, mk(3'd2, 32'h22, 5'd7));
        @(negedge clk_i) chk("t036_ch1", 64'(bus.ch_ready_o), 64'b010);
        tick();
        bus.ch_valid_i[1] = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            @(negedge clk_i);
            if (bus.ch_ready_o[2]) begin
                got = 1;
                chk("t036_after_retire", 64'(next_id_o), 64'd4);
            end
            tick();
        end
        chk("t036_ch2_accepted", 64'(got), 64'd1);
        idle();
        do_reset("t036");

        // Kill: ID0 retires silently, ID1 follows
        bus.res_ready_i = 1'b1;
        exp_q.push_back(mk(3'd1, 32'h11, 5'd4));
        kill_valid_i = 1'b1;
        kill_id_i    = 3'd0;
        drv(0, mk(3'd1, 32'h11, 5'd4));
        @(negedge clk_i) chk("t037_c0_valid", 64'(bus.res_valid_o), 64'd0);
        tick(); idle();
        @(negedge clk_i) chk("t037_kill_silent", 64'(bus.res_valid_o), 64'd0);
        tick();
        @(negedge clk_i) begin
            chk("t037_id1_valid", 64'(bus.res_valid_o), 64'd1);
            chk("t037_id1_id", 64'(bus.res_id_o), 64'd1);
        end
        tick();
        chk("t037_next", 64'(next_id_o), 64'd2);
        // Kill beats a same-cycle write to the same ID
        kill_valid_i = 1'b1;
        kill_id_i    = 3'd2;
        drv(0, mk(3'd2, 32'h99, 5'd9));
        tick(); idle();
        tick();
        chk("t037_kill_prio_next", 64'(next_id_o), 64'd3);
        chk("t037_kill_prio_occ", 64'(occupancy_o), 64'd0);
        do_reset("t037");

        // Three accepts per cycle, then full ROB across the wrap point
        bus.res_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back(pl(3'(i)));
        drv(0, pl(3'd0)); drv(1, pl(3'd1)); drv(2, pl(3'd2));
        @(negedge clk_i) chk("t038_triple", 64'(bus.ch_ready_o), 64'b111);
        tick(); idle();
        chk("t038_occ3", 64'(occupancy_o), 64'd3);
        drv(0, pl(3'd3)); drv(1, pl(3'd4)); drv(2, pl(3'd5));
        tick(); idle();
        chk("t038_occ6", 64'(occupancy_o), 64'd6);
        bus.res_ready_i = 1'b1;
        repeat (6) tick();
        chk("t038_next6", 64'(next_id_o), 64'd6);
        chk("t038_occ0a", 64'(occupancy_o), 64'd0);
        bus.res_ready_i = 1'b0;
        exp_q.push_back(pl(3'd6));
        exp_q.push_back(pl(3'd7));
        for (int i = 0; i < 6; i++) exp_q.push_back(pl(3'(i)));
        drv(0, pl(3'd6)); drv(1, pl(3'd7)); drv(2, pl(3'd0));
        tick(); idle();
        drv(0, pl(3'd1)); drv(1, pl(3'd2)); drv(2, pl(3'd3));
        tick(); idle();
        drv(0, pl(3'd4)); drv(1, pl(3'd5));
        tick(); idle();
        chk("t038_occ8", 64'(occupancy_o), 64'd8);
        drv(0, pl(3'd6)); drv(1, pl(3'd1)); drv(2, pl(3'd4));
        @(negedge clk_i) begin
            chk("t038_full_stall", 64'(bus.ch_ready_o), 64'b000);
            chk("t038_head_id", 64'(bus.res_id_o), 64'd6);
        end
        tick(); idle();
        bus.res_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i) chk("t038_occ_dec", 64'(occupancy_o), 64'(8 - k));
            tick();
        end
        chk("t038_occ0b", 64'(occupancy_o), 64'd0);
        chk("t038_wrap_next", 64'(next_id_o), 64'd6);
        do_reset("t038");

        // Stall stability, then reset mid-stall discards the result
        bus.res_ready_i = 1'b0;
        drv(0, mk(3'd0, 32'hC0DE, 5'd5));
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i) begin
                chk("t039_hold_valid", 64'(bus.res_valid_o), 64'd1);
                chk("t039_hold_pl", 64'({bus.res_id_o, bus.res_data_o, bus.res_rd_o}),
                    64'({3'd0, 32'hC0DE, 5'd5}));
            end
            tick();
        end
        #2;
        async_rst_ni = 1'b0;
        drv(0, mk(3'd1, 32'h1, 5'd1));
        #1;
        chk("t039_rst_valid", 64'(bus.res_valid_o), 64'd0);
        chk("t039_rst_occ", 64'(occupancy_o), 64'd0);
        chk("t039_rst_next", 64'(next_id_o), 64'd0);
        chk("t039_rst_ready", 64'(bus.ch_ready_o), 64'd0);
        idle();
        tick();
        async_rst_ni = 1'b1;
        bus.res_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i) chk("t039_discarded", 64'(bus.res_valid_o), 64'd0);
            tick();
        end

        // Acceptance-to-result latency (same cycle only with bypass)
        exp_q.push_back(mk(3'd0, 32'h77, 5'd8));
        drv(1, mk(3'd0, 32'h77, 5'd8));
        @(negedge clk_i) begin
`ifdef VPROC_RESULT_BYPASS_EN
            chk("t040_same_valid", 64'(bus.res_valid_o), 64'd1);
            chk("t040_same_data", 64'(bus.res_data_o), 64'h77);
`else
            chk("t040_same_valid", 64'(bus.res_valid_o), 64'd0);
`endif
        end
        tick(); idle();
        @(negedge clk_i) begin
`ifdef VPROC_RESULT_BYPASS_EN
            chk("t040_next_valid", 64'(bus.res_valid_o), 64'd0);
`else
            chk("t040_next_valid", 64'(bus.res_valid_o), 64'd1);
            chk("t040_next_data", 64'(bus.res_data_o), 64'h77);
`endif
        end
        tick();
        chk("t040_next_id", 64'(next_id_o), 64'd1);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
